// File: rtl/wc_pkg.sv
// Shared constants and types for the Winograd F(2,3) datapath and its
// feeders.
package wc_pkg;

  localparam int WC_DW   = 10;
  localparam int WC_M    = 2;
  localparam int WC_R    = 3;
  localparam int WC_TILE = WC_M + WC_R - 1;

  typedef logic signed [WC_DW-1:0] wc_sample_t;

  typedef enum logic [1:0] {
    FILL,
    PAIR,
    HOLD
  } wc_state_e;

endpackage

// File: rtl/wc_tile_loader_if.sv
// Sample-stream and tile handshake bundle for wc_tile_loader. The loader sits
// on the slave modport and the upstream/downstream environment sits on the
// master modport.
interface wc_tile_loader_if #(
  parameter int DW = wc_pkg::WC_DW
);

  logic                          in_valid;
  logic signed [DW-1:0]          in_data;
  logic                          in_ready;
  logic                          tile_valid;
  logic                          tile_ready;
  logic [wc_pkg::WC_TILE*DW-1:0] D;
  logic                          tile_last;

  modport master (
    output in_valid,
    output in_data,
    output tile_ready,
    input  in_ready,
    input  tile_valid,
    input  D,
    input  tile_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  tile_ready,
    output in_ready,
    output tile_valid,
    output D,
    output tile_last
  );

endinterface

// File: rtl/wc_tile_loader.sv
// Turns a serial row of samples into overlapping stride-2 4-sample tiles for
// the Winograd core, and holds each tile until downstream releases it.
module wc_tile_loader
  import wc_pkg::*;
#(
  parameter int DW      = WC_DW,
  parameter int ROW_LEN = 8
) (
  input logic             clk,
  input logic             rst,
  wc_tile_loader_if.slave bus
);

  localparam int COL_W = $clog2(ROW_LEN + 1);
  localparam int WIN_W = WC_TILE * DW;
  localparam logic [COL_W-1:0] FIRST_TILE_COL = COL_W'(WC_TILE);
  localparam logic [COL_W-1:0] ROW_END_COL    = COL_W'(ROW_LEN);

  wc_state_e        state_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [1:0]       pc_q, pc_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             accept;
  logic             lastTile;

  assign accept   = bus.in_valid && (state_q != HOLD);
  assign lastTile = (state_q == HOLD) && (col_q == ROW_END_COL);

  assign win_d = {win_q[WIN_W-DW-1:0], bus.in_data};
  assign col_d = col_q + 1'b1;
  assign pc_d  = pc_q + 2'd1;

  assign bus.in_ready   = (state_q != HOLD);
  assign bus.tile_valid = (state_q == HOLD);
  assign bus.tile_last  = lastTile;
  assign bus.D          = win_q;

  // The window is never cleared between rows; the 4 fresh samples of the next
  // row overwrite it completely before the next tile is shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      col_q   <= '0;
      pc_q    <= '0;
      win_q   <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            win_q <= win_d;
            col_q <= col_d;
            if (col_d == FIRST_TILE_COL) begin
              state_q <= HOLD;
            end
          end
        end
        PAIR: begin
          if (accept) begin
            win_q <= win_d;
            col_q <= col_d;
            pc_q  <= pc_d;
            if (pc_q == 2'd1) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.tile_ready) begin
            if (lastTile) begin
              col_q   <= '0;
              state_q <= FILL;
            end else begin
              pc_q    <= '0;
              state_q <= PAIR;
            end
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wc_tile_loader.sv
// Self-checking bench for wc_tile_loader: table-driven rows with a tile
// scoreboard, plus backpressure and mid-row reset sequences.
module tb_wc_tile_loader;

  logic clk;
  logic rst;

  wc_tile_loader_if #(.DW(10)) bus ();

  wc_tile_loader #(.DW(10), .ROW_LEN(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          s[8];
    int          gapMask;
    logic [39:0] exp[3];
  } vec_t;

  typedef struct packed {
    logic [39:0] d;
    logic        last;
  } exp_t;

  vec_t vecs[4];
  exp_t sbq[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   tilesSeen  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [39:0] pack4(input int a, input int b, input int c, input int d);
    return {10'(a), 10'(b), 10'(c), 10'(d)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered and left just after a rising edge; handshake decisions are read
  // on the falling edge where in_ready is stable.
  task automatic applyStimulus(input int v, input int gap);
    int waitCycles;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 10'(v);
    waitCycles   = 0;
    @(negedge clk);
    while (!bus.in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("in_ready_seen", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pushTile(input logic [39:0] d, input logic last);
    exp_t e;
    e.d    = d;
    e.last = last;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.tile_valid && bus.tile_ready) begin
      exp_t e;
      tilesSeen++;
      if (sbq.size() == 0) begin
        checkOutput("tile_expected", 64'(sbq.size()), 64'd1);
      end else begin
        e = sbq.pop_front();
        checkOutput("tile_D", 64'(bus.D), 64'(e.d));
        checkOutput("tile_last", 64'(bus.tile_last), 64'(e.last));
      end
    end
  end

  initial begin
    vecs[0].s       = '{2, -10, 3, 4, -19, -6, 3, -9};
    vecs[0].gapMask = 0;
    vecs[0].exp     = '{40'b0000000010_1111110110_0000000011_0000000100,
                        pack4(3, 4, -19, -6), pack4(-19, -6, 3, -9)};
    vecs[1].s       = '{1, 2, 3, 4, 5, 6, 7, 8};
    vecs[1].gapMask = 0;
    vecs[1].exp     = '{pack4(1, 2, 3, 4), pack4(3, 4, 5, 6), pack4(5, 6, 7, 8)};
    vecs[2].s       = '{-512, 511, 0, -1, 1, -2, 256, -256};
    vecs[2].gapMask = 0;
    vecs[2].exp     = '{pack4(-512, 511, 0, -1), pack4(0, -1, 1, -2), pack4(1, -2, 256, -256)};
    vecs[3].s       = '{2, -10, 3, 4, -19, -6, 3, -9};
    vecs[3].gapMask = 'b1010_0100;
    vecs[3].exp     = vecs[0].exp;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.tile_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset_tile_valid", 64'(bus.tile_valid), 64'd0);
    checkOutput("reset_tile_last", 64'(bus.tile_last), 64'd0);
    checkOutput("reset_D", 64'(bus.D), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Rows back to back: covers row boundaries and in_valid gaps.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 3) pushTile(vecs[v].exp[0], 1'b0);
        if (i == 5) pushTile(vecs[v].exp[1], 1'b0);
        if (i == 7) pushTile(vecs[v].exp[2], 1'b1);
        applyStimulus(vecs[v].s[i], vecs[v].gapMask[i] ? 2 : 0);
        if (v == 0 && (i == 2 || i == 3)) begin
          @(negedge clk);
          checkOutput("first_tile_timing", 64'(bus.tile_valid), (i == 3) ? 64'd1 : 64'd0);
          @(posedge clk);
          #1;
        end
      end
      if (v == 1) begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("tiles_two_rows", 64'(tilesSeen), 64'd6);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("tiles_after_table", 64'(tilesSeen), 64'd12);

    // Backpressure: the pending sample must wait out HOLD and then be taken.
    bus.tile_ready = 1'b0;
    pushTile(pack4(1, 2, 3, 4), 1'b0);
    for (int i = 1; i <= 4; i++) applyStimulus(i, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 10'sd5;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checkOutput("bp_D_stable", 64'(bus.D), 64'(pack4(1, 2, 3, 4)));
      checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("bp_tile_valid", 64'(bus.tile_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.tile_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_after_hs_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("bp_after_hs_tile_valid", 64'(bus.tile_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    pushTile(pack4(3, 4, 5, 6), 1'b0);
    applyStimulus(6, 0);
    pushTile(pack4(5, 6, 7, 8), 1'b1);
    applyStimulus(7, 0);
    applyStimulus(8, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset in PAIR after 5 samples, then a fresh row.
    pushTile(pack4(11, 12, 13, 14), 1'b0);
    for (int i = 11; i <= 15; i++) applyStimulus(i, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_D", 64'(bus.D), 64'd0);
    checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("midrst_tile_valid", 64'(bus.tile_valid), 64'd0);
    checkOutput("midrst_tile_last", 64'(bus.tile_last), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushTile(pack4(21, 22, 23, 24), 1'b0);
    for (int i = 21; i <= 24; i++) applyStimulus(i, 0);
    pushTile(pack4(23, 24, 25, 26), 1'b0);
    applyStimulus(25, 0);
    applyStimulus(26, 0);
    pushTile(pack4(25, 26, 27, 28), 1'b1);
    applyStimulus(27, 0);
    applyStimulus(28, 0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("tiles_total", 64'(tilesSeen), 64'd19);
    checkOutput("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
